basilisk_result_arbiter: RTL

- Downstream neighbour of the float encode unit.
- Merges the gecko_operation_t result streams from the basilisk integer-producing units (encode, float-to-int move, memory/convert) into one registered writeback stream toward the gecko integer register file.
- Round-robin fairness across sources; one result retired per cycle; fixed one-cycle latency.

---
 rtl/basilisk_pkg.sv | 14 +
 rtl/gecko_pkg.sv | 10 +
 rtl/basilisk_rr_arbiter.sv | 32 +++
 rtl/basilisk_result_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/basilisk_pkg.sv
// Basilisk result-source identifiers and small helpers used by the result arbiter.
package basilisk_pkg;

    localparam int unsigned BASILISK_RESULT_SOURCE_ENCODE = 32'd0;
    localparam int unsigned BASILISK_RESULT_SOURCE_MOVE   = 32'd1;
    localparam int unsigned BASILISK_RESULT_SOURCE_MEMORY = 32'd2;
    localparam int unsigned BASILISK_NUM_RESULT_SOURCES   = BASILISK_RESULT_SOURCE_MEMORY + 32'd1;

    // True when two or more bits are set: clearing the lowest set bit leaves something behind.
    function automatic logic at_least_two(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/gecko_pkg.sv
// Shared gecko operation record carried from execution units to the integer register file.
package gecko_pkg;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] value;
        logic        speculative;
    } gecko_operation_t;

endpackage

// File: rtl/basilisk_rr_arbiter.sv
// Combinational N-way round-robin grant: first requester found scanning from pointer upward, wrapping.
module basilisk_rr_arbiter #(
    parameter  int unsigned N     = 32'd3,
    localparam int unsigned IDX_W = (N > 32'd1) ? $clog2(N) : 32'd1
) (
    input  logic [N-1:0]     request,
    input  logic [IDX_W-1:0] pointer,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_index
);

    logic             found_s;
    logic             hit_s;
    logic [IDX_W-1:0] idx_s;

    // Rotating priority scan; hit_s fires only for the first requester reached.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        found_s     = 1'b0;
        hit_s       = 1'b0;
        idx_s       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx_s              = IDX_W'((32'(pointer) + off) % N);
            hit_s              = !found_s && request[idx_s];
            grant[idx_s]       = grant[idx_s] | hit_s;
            grant_index        = hit_s ? idx_s : grant_index;
            found_s            = found_s | hit_s;
        end
    end

endmodule

// File: rtl/basilisk_result_arbiter.sv
// Merges basilisk integer result streams into one registered, round-robin writeback stream.
module basilisk_result_arbiter
    import gecko_pkg::*;
    import basilisk_pkg::*;
#(
    parameter  int unsigned NUM_SOURCES = BASILISK_NUM_RESULT_SOURCES,
    parameter  int unsigned COUNT_WIDTH = 32'd16,
    localparam int unsigned IDX_W       = (NUM_SOURCES > 32'd1) ? $clog2(NUM_SOURCES) : 32'd1,
    localparam int unsigned OP_W        = $bits(gecko_operation_t)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SOURCES-1:0]      result_valid,
    output logic [NUM_SOURCES-1:0]      result_ready,
    input  logic [NUM_SOURCES*OP_W-1:0] result_payload,
    output logic                        writeback_valid,
    input  logic                        writeback_ready,
    output gecko_operation_t            writeback_payload,
    output logic [IDX_W-1:0]            writeback_source,
    output logic [COUNT_WIDTH-1:0]      conflict_count
);

    gecko_operation_t       ops_s [NUM_SOURCES];
    gecko_operation_t       granted_op_s;
    logic [NUM_SOURCES-1:0] grant_s;
    logic [IDX_W-1:0]       grant_index_s;
    logic                   can_load_s;
    logic                   transfer_s;

    logic                   wb_valid_q,   wb_valid_d;
    gecko_operation_t       wb_payload_q, wb_payload_d;
    logic [IDX_W-1:0]       wb_source_q,  wb_source_d;
    logic [IDX_W-1:0]       rr_ptr_q,     rr_ptr_d;
    logic [COUNT_WIDTH-1:0] conflict_q,   conflict_d;

    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_unpack
        assign ops_s[i] = result_payload[i*OP_W +: OP_W];
    end

    basilisk_rr_arbiter #(
        .N (NUM_SOURCES)
    ) u_rr_arbiter (
        .request     (result_valid),
        .pointer     (rr_ptr_q),
        .grant       (grant_s),
        .grant_index (grant_index_s)
    );

    // Handshake and next-state; ready is gated by reset so no source handshakes while held in reset.
    always_comb begin
        can_load_s   = !wb_valid_q || writeback_ready;
        transfer_s   = rst && can_load_s && (|result_valid);
        result_ready = (rst && can_load_s) ? grant_s : '0;
        granted_op_s = ops_s[grant_index_s];

        wb_valid_d   = wb_valid_q;
        wb_payload_d = wb_payload_q;
        wb_source_d  = wb_source_q;
        rr_ptr_d     = rr_ptr_q;
        conflict_d   = conflict_q;

        if (transfer_s) begin
            wb_valid_d               = 1'b1;
            wb_payload_d             = granted_op_s;
            wb_payload_d.speculative = 1'b0;
            wb_source_d              = grant_index_s;
            rr_ptr_d                 = (grant_index_s == IDX_W'(NUM_SOURCES - 32'd1)) ? '0
                                                                                     : grant_index_s + 1'b1;
            if (at_least_two(32'(result_valid)) && (conflict_q != '1)) begin
                conflict_d = conflict_q + 1'b1;
            end else begin
                conflict_d = conflict_q;
            end
        end else if (can_load_s) begin
            // Drained (or already empty) with nothing to refill: payload and source keep old values.
            wb_valid_d = 1'b0;
        end else begin
            wb_valid_d = wb_valid_q;
        end
    end

    // Output register, round-robin pointer and saturating conflict counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q   <= 1'b0;
            wb_payload_q <= '0;
            wb_source_q  <= '0;
            rr_ptr_q     <= '0;
            conflict_q   <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_payload_q <= wb_payload_d;
            wb_source_q  <= wb_source_d;
            rr_ptr_q     <= rr_ptr_d;
            conflict_q   <= conflict_d;
        end
    end

    assign writeback_valid   = wb_valid_q;
    assign writeback_payload = wb_payload_q;
    assign writeback_source  = wb_source_q;
    assign conflict_count    = conflict_q;

endmodule
